to_upper: RTL and testbench

TO_UPPER -- requirements
Module: to_upper

---
 rtl/to_upper_if.sv | 28 ++
 rtl/to_upper.sv | 106 ++++++++++
 tb/tb_to_upper.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/to_upper_if.sv
// Byte stream bus for the case converter: input handshake, output handshake,
// mode select and the converted-character counter.
interface to_upper_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_changed;
  logic [CNT_W-1:0] conv_count;
  logic             cnt_clr;

  // The converter sits on this side.
  modport slave (
    input  in_data, in_valid, mode, out_ready, cnt_clr,
    output in_ready, out_data, out_valid, out_changed, conv_count
  );

  // The producer/consumer around the converter sits on this side.
  modport master (
    output in_data, in_valid, mode, out_ready, cnt_clr,
    input  in_ready, out_data, out_valid, out_changed, conv_count
  );
endinterface

// File: rtl/to_upper.sv
// ASCII case converter: one-deep output register with full-throughput
// valid/ready handshake, per-byte mode, and a saturating count of
// delivered bytes that were actually modified.

typedef enum logic [1:0] {
  MODE_UPPER = 2'b00,
  MODE_LOWER = 2'b01,
  MODE_SWAP  = 2'b10,
  MODE_PASS  = 2'b11
} case_mode_e;

// Pure combinational byte converter. Only bit 5 of a letter is ever
// touched, so "changed" is exactly "bit 5 was flipped".
module to_upper_conv (
  input  logic [7:0] din,
  input  logic [1:0] mode,
  output logic [7:0] dout,
  output logic       changed
);
  logic is_lo;
  logic is_up;
  logic flip;

  assign is_lo = (din >= 8'h61) && (din <= 8'h7A);
  assign is_up = (din >= 8'h41) && (din <= 8'h5A);

  // Decide whether this byte's case bit is flipped under the given mode.
  always_comb begin
    flip = 1'b0;
    case (case_mode_e'(mode))
      MODE_UPPER: flip = is_lo;
      MODE_LOWER: flip = is_up;
      MODE_SWAP:  flip = is_lo | is_up;
      MODE_PASS:  flip = 1'b0;
      default:    flip = 1'b0;
    endcase
  end

  assign dout    = din ^ {2'b00, flip, 5'b00000};
  assign changed = flip;
endmodule

module to_upper #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  to_upper_if.slave    bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]       conv_data;
  logic             conv_chg;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_changed;
  logic [CNT_W-1:0] conv_count;
  logic             in_ready;
  logic             accept;
  logic             consume;

  to_upper_conv u_conv (
    .din     (bus.in_data),
    .mode    (bus.mode),
    .dout    (conv_data),
    .changed (conv_chg)
  );

  // The slot frees up in the same cycle it is drained, giving one byte/cycle.
  assign in_ready = !out_valid || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign consume  = out_valid && bus.out_ready;

  // Output register: load on accept (even while draining), clear when drained
  // with nothing new arriving, otherwise hold regardless of mode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_changed <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= conv_data;
      out_changed <= conv_chg;
    end else if (consume) begin
      out_valid   <= 1'b0;
    end
  end

  // Count modified bytes as they leave; clear wins, and the count sticks at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count <= '0;
    end else if (bus.cnt_clr) begin
      conv_count <= '0;
    end else if (consume && out_changed && (conv_count != CNT_MAX)) begin
      conv_count <= conv_count + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_data    = out_data;
  assign bus.out_valid   = out_valid;
  assign bus.out_changed = out_changed;
  assign bus.conv_count  = conv_count;
endmodule

// File: tb/tb_to_upper.sv
// Directed bench for to_upper: streaming, range boundaries, all modes,
// backpressure, async reset, counter clear and saturation.
module tb_to_upper;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  to_upper_if #(.CNT_W(16)) bus ();
  to_upper_if #(.CNT_W(2))  bus2 ();

  to_upper #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  to_upper #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single isolated transfer with out_ready high.
  task automatic xfer(input string tag, input logic [1:0] m, input logic [7:0] d,
                      input logic [7:0] exp, input logic chg);
    bus.mode     = m;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    step();
    check({tag, "_data"}, {8'h00, bus.out_data}, {8'h00, exp});
    check({tag, "_chg"},  {15'h0, bus.out_changed}, {15'h0, chg});
    check({tag, "_vld"},  {15'h0, bus.out_valid}, 16'h1);
    bus.in_valid = 1'b0;
    step();
  endtask

  logic [7:0] s_in  [19] = '{8'h28,8'h48,8'hB7,8'h83,8'h7C,8'h14,8'hEB,8'h61,8'h41,8'h7A,
                             8'h47,8'h6D,8'h92,8'h30,8'hCF,8'h3A,8'h7B,8'h94,8'h7F};
  logic [7:0] s_out [19] = '{8'h28,8'h48,8'hB7,8'h83,8'h7C,8'h14,8'hEB,8'h41,8'h41,8'h5A,
                             8'h47,8'h4D,8'h92,8'h30,8'hCF,8'h3A,8'h7B,8'h94,8'h7F};

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.mode = 2'b00;
    bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    bus2.in_data = 8'h00; bus2.in_valid = 1'b0; bus2.mode = 2'b00;
    bus2.out_ready = 1'b1; bus2.cnt_clr = 1'b0;
    #12;
    check("rst_vld",   {15'h0, bus.out_valid}, 16'h0);
    check("rst_data",  {8'h00, bus.out_data}, 16'h0000);
    check("rst_chg",   {15'h0, bus.out_changed}, 16'h0);
    check("rst_cnt",   bus.conv_count, 16'h0);
    check("rst_rdy",   {15'h0, bus.in_ready}, 16'h1);
    rst_n = 1'b1;
    step();

    // Streaming, mode 00, one byte per cycle.
    for (int i = 0; i < 19; i++) begin
      bus.in_data  = s_in[i];
      bus.in_valid = 1'b1;
      step();
      check($sformatf("stream%0d", i), {8'h00, bus.out_data}, {8'h00, s_out[i]});
      check($sformatf("stream%0d_v", i), {15'h0, bus.out_valid}, 16'h1);
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_cnt",  bus.conv_count, 16'd3);
    check("stream_idle", {15'h0, bus.out_valid}, 16'h0);

    // Range boundaries and remaining modes.
    xfer("u60", 2'b00, 8'h60, 8'h60, 1'b0);
    xfer("u61", 2'b00, 8'h61, 8'h41, 1'b1);
    xfer("u7a", 2'b00, 8'h7A, 8'h5A, 1'b1);
    xfer("u7b", 2'b00, 8'h7B, 8'h7B, 1'b0);
    xfer("l40", 2'b01, 8'h40, 8'h40, 1'b0);
    xfer("l41", 2'b01, 8'h41, 8'h61, 1'b1);
    xfer("l5a", 2'b01, 8'h5A, 8'h7A, 1'b1);
    xfer("l5b", 2'b01, 8'h5B, 8'h5B, 1'b0);
    xfer("s61", 2'b10, 8'h61, 8'h41, 1'b1);
    xfer("s41", 2'b10, 8'h41, 8'h61, 1'b1);
    xfer("se1", 2'b10, 8'hE1, 8'hE1, 1'b0);
    xfer("p61", 2'b11, 8'h61, 8'h61, 1'b0);
    check("bound_cnt", bus.conv_count, 16'd9);

    // Clear the counter.
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    check("clr_cnt", bus.conv_count, 16'd0);

    // Backpressure: byte held stable, second byte waits, mode change ignored.
    bus.mode = 2'b00; bus.out_ready = 1'b0;
    bus.in_data = 8'h61; bus.in_valid = 1'b1;
    step();
    check("bp_first", {8'h00, bus.out_data}, 16'h0041);
    bus.in_data = 8'h62; bus.mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_rdy%0d", i), {15'h0, bus.in_ready}, 16'h0);
      step();
      check($sformatf("bp_hold%0d", i), {8'h00, bus.out_data}, 16'h0041);
      check($sformatf("bp_chg%0d", i), {15'h0, bus.out_changed}, 16'h1);
    end
    bus.mode = 2'b00; bus.out_ready = 1'b1;
    step();
    check("bp_second", {8'h00, bus.out_data}, 16'h0042);
    check("bp_vld",    {15'h0, bus.out_valid}, 16'h1);
    bus.in_valid = 1'b0;
    step();
    check("bp_cnt", bus.conv_count, 16'd2);

    // Build count to 5 with a changed byte still held, then reset between edges.
    bus.in_data = 8'h61; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("pre_rst_cnt", bus.conv_count, 16'd5);
    check("pre_rst_vld", {15'h0, bus.out_valid}, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld",  {15'h0, bus.out_valid}, 16'h0);
    check("arst_data", {8'h00, bus.out_data}, 16'h0000);
    check("arst_cnt",  bus.conv_count, 16'd0);
    check("arst_rdy",  {15'h0, bus.in_ready}, 16'h1);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_cnt", bus.conv_count, 16'd0);

    // First byte after reset, then clear racing a changed handshake.
    bus.in_data = 8'h7A; bus.in_valid = 1'b1;
    step();
    check("post_rst_data", {8'h00, bus.out_data}, 16'h005A);
    bus.in_valid = 1'b0; bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    check("clr_race_cnt", bus.conv_count, 16'd0);
    check("clr_race_vld", {15'h0, bus.out_valid}, 16'h0);

    // Saturation with a 2-bit counter.
    bus2.in_data = 8'h61; bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus2.in_valid = 1'b0;
    step();
    check("sat_cnt", {14'h0, bus2.conv_count}, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
